// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_pkg
// Purpose  : Shared state encoding for the 8085 clock stepper.
// Revision : 1.0  initial release
// ============================================================================
package cpu_clk_pkg;

  localparam int STATE_W = 2;

  // 2'b11 is deliberately left unused; the FSM recovers it to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_PEND = 2'b10
  } state_e;

endpackage : cpu_clk_pkg
`default_nettype wire

// File: rtl/cpu_clk_stepper_debounce.sv
`default_nettype none
// ============================================================================
// Module   : step_debounce
// Purpose  : Synchronizes and debounces the STEP push-button, emitting a
//            one-cycle pulse when the accepted level goes 0->1.
// Revision : 1.0  initial release
// ============================================================================
module step_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic step_evt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   evt_q, evt_d;
  logic                   w_sync;

  assign w_sync = sync_q[SYNC_STAGES-1];

  // Count only while the synchronized level disagrees with the accepted one;
  // any agreement (a bounce back) restarts the stability window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (w_sync != stable_q) begin
      if (cnt_q == C_LAST) begin
        stable_d = w_sync;
        evt_d    = w_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
    end
  end

  assign step_evt_o = evt_q;

endmodule : step_debounce
`default_nettype wire

// File: rtl/cpu_clk_stepper.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_stepper
// Purpose  : Turns slow_clk rising edges into cpu_ce pulses with RUN / STEP /
//            HALT control and a wrapping pulse counter.
// Revision : 1.0  initial release
// ============================================================================
module cpu_clk_stepper
  import cpu_clk_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 slow_clk,
  input  logic                 run_mode,
  input  logic                 step_btn,
  input  logic                 halt_req,
  input  logic                 cnt_clr,
  output logic                 cpu_ce,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic [STATE_W-1:0]   state
);

  logic [SYNC_STAGES-1:0] slow_sync_q;
  logic                   slow_hist_q;
  logic                   w_slow_rise;
  logic                   w_step_evt;
  state_e                 state_q, state_d;
  logic                   cpu_ce_q, cpu_ce_d;
  logic [CNT_WIDTH-1:0]   tick_q, tick_d;

  assign w_slow_rise = slow_sync_q[SYNC_STAGES-1] & ~slow_hist_q;

  step_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debounce (
    .clk_i     (clk_in),
    .rst_i     (reset),
    .btn_i     (step_btn),
    .step_evt_o(w_step_evt)
  );

  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt_req)        state_d = ST_IDLE;
        else if (run_mode)   state_d = ST_RUN;
        else if (w_step_evt) state_d = ST_STEP_PEND;
      end
      ST_RUN: begin
        if (halt_req || !run_mode) state_d = ST_IDLE;
        else                       cpu_ce_d = w_slow_rise;
      end
      ST_STEP_PEND: begin
        // A second press while pending is simply not looked at.
        if (halt_req) begin
          state_d = ST_IDLE;
        end else if (w_slow_rise) begin
          cpu_ce_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_d = tick_q + CNT_WIDTH'(cpu_ce_q);
    if (cnt_clr) tick_d = '0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      slow_sync_q <= '0;
      slow_hist_q <= 1'b0;
      state_q     <= ST_IDLE;
      cpu_ce_q    <= 1'b0;
      tick_q      <= '0;
    end else begin
      slow_sync_q <= {slow_sync_q[SYNC_STAGES-2:0], slow_clk};
      slow_hist_q <= slow_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      cpu_ce_q    <= cpu_ce_d;
      tick_q      <= tick_d;
    end
  end

  assign cpu_ce     = cpu_ce_q;
  assign tick_count = tick_q;
  assign state      = state_q;

endmodule : cpu_clk_stepper
`default_nettype wire

// File: tb/tb_cpu_clk_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clk_stepper
// Purpose  : Directed self-checking bench for cpu_clk_stepper.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_clk_stepper;
  import cpu_clk_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        slow_clk = 1'b0;
  logic        run_mode = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        cpu_ce;
  logic [15:0] tick_count;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  cpu_clk_stepper #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (16)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .slow_clk  (slow_clk),
    .run_mode  (run_mode),
    .step_btn  (step_btn),
    .halt_req  (halt_req),
    .cnt_clr   (cnt_clr),
    .cpu_ce    (cpu_ce),
    .tick_count(tick_count),
    .state     (state)
  );

  always #5 clk_in = ~clk_in;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // One 20-cycle slow_clk period. Edge e counts clk_in edges after the rise.
  task automatic slow_period(input int halt_e, input int clr_e,
                             output int np, output int fe, output int dbl,
                             output logic [1:0] st3);
    logic prev;
    np = 0; fe = 0; dbl = 0; st3 = 2'b00; prev = 1'b0;
    @(posedge clk_in);
    #1;
    slow_clk = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk_in);
      #1;
      if (cpu_ce) begin
        np++;
        if (fe == 0) fe = e;
        if (prev) dbl++;
      end
      prev = cpu_ce;
      if (e == 3) st3 = state;
      if (halt_e > 0 && e == halt_e) halt_req = 1'b1;
      if (halt_e > 0 && e == halt_e + 1) halt_req = 1'b0;
      if (clr_e > 0 && e == clr_e) cnt_clr = 1'b1;
      if (clr_e > 0 && e == clr_e + 1) cnt_clr = 1'b0;
      if (e == 10) slow_clk = 1'b0;
    end
  endtask

  task automatic press_button();
    step_btn = 1'b1;
    idle(8);
    step_btn = 1'b0;
    idle(8);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %0h expected 0", cpu_ce); end
    checks++; if (tick_count !== 16'h0) begin errors++; $display("FAIL reset_tick: got %0h expected 0", tick_count); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0h expected %0h", state, ST_IDLE); end
    @(negedge clk_in);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_run();
    int np, fe, dbl;
    logic [1:0] st3;
    run_mode = 1'b1;
    idle(2);
    checks++; if (state !== ST_RUN) begin errors++; $display("FAIL run_state: got %0h expected %0h", state, ST_RUN); end
    for (int i = 0; i < 3; i++) begin
      slow_period(0, 0, np, fe, dbl, st3);
      checks++; if (np !== 1 || fe !== 3 || dbl !== 0) begin
        errors++; $display("FAIL run_pulse%0d: got count=%0d edge=%0d dbl=%0d expected 1/3/0", i, np, fe, dbl);
      end
    end
    checks++; if (tick_count !== 16'd3) begin errors++; $display("FAIL run_tick: got %0h expected 3", tick_count); end
  endtask

  task automatic test_reset_mid_run();
    int np, fe, dbl;
    logic [1:0] st3;
    repeat (2) slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (tick_count !== 16'd5) begin errors++; $display("FAIL mid_tick_pre: got %0h expected 5", tick_count); end
    @(posedge clk_in);
    #1;
    slow_clk = 1'b1;
    idle(3);
    checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL mid_ce_pre: got %0h expected 1", cpu_ce); end
    reset = 1'b1;
    #1;
    checks++; if (cpu_ce !== 1'b0 || tick_count !== 16'h0 || state !== ST_IDLE) begin
      errors++; $display("FAIL mid_reset: got ce=%0h tick=%0h st=%0h expected 0/0/0", cpu_ce, tick_count, state);
    end
    slow_clk = 1'b0;
    run_mode = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (cpu_ce) np++;
    end
    checks++; if (np !== 0 || tick_count !== 16'h0) begin
      errors++; $display("FAIL mid_release: got pulses=%0d tick=%0h expected 0/0", np, tick_count);
    end
  endtask

  task automatic test_step();
    int np, fe, dbl, tot;
    logic [1:0] st3;
    idle(2);
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL step_idle: got %0h expected %0h", state, ST_IDLE); end
    step_btn = 1'b1; idle(1);
    step_btn = 1'b0; idle(1);
    step_btn = 1'b1; idle(6);
    idle(3);
    checks++; if (state !== ST_STEP_PEND) begin errors++; $display("FAIL step_pend: got %0h expected %0h", state, ST_STEP_PEND); end
    checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL step_early: got %0h expected 0", cpu_ce); end
    slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (np !== 1 || fe !== 3) begin
      errors++; $display("FAIL step_pulse: got count=%0d edge=%0d expected 1/3", np, fe);
    end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL step_back: got %0h expected %0h", state, ST_IDLE); end
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      slow_period(0, 0, np, fe, dbl, st3);
      tot += np;
    end
    checks++; if (tot !== 0) begin errors++; $display("FAIL step_hold: got %0d extra pulses expected 0", tot); end
    step_btn = 1'b0;
    idle(10);
    checks++; if (state !== ST_IDLE || tick_count !== 16'd1) begin
      errors++; $display("FAIL step_release: got st=%0h tick=%0h expected 0/1", state, tick_count);
    end
  endtask

  task automatic test_no_queue();
    int np1, np2, fe, dbl;
    logic [1:0] st3;
    press_button();
    press_button();
    checks++; if (state !== ST_STEP_PEND) begin errors++; $display("FAIL noq_pend: got %0h expected %0h", state, ST_STEP_PEND); end
    slow_period(0, 0, np1, fe, dbl, st3);
    slow_period(0, 0, np2, fe, dbl, st3);
    checks++; if (np1 !== 1 || np2 !== 0) begin
      errors++; $display("FAIL noq_pulses: got %0d,%0d expected 1,0", np1, np2);
    end
    checks++; if (tick_count !== 16'd2) begin errors++; $display("FAIL noq_tick: got %0h expected 2", tick_count); end
  endtask

  task automatic test_halt();
    int np, fe, dbl;
    logic [1:0] st3;
    run_mode = 1'b1;
    idle(2);
    slow_period(2, 0, np, fe, dbl, st3);
    checks++; if (np !== 0) begin errors++; $display("FAIL halt_pulse: got %0d expected 0", np); end
    checks++; if (st3 !== ST_IDLE) begin errors++; $display("FAIL halt_state: got %0h expected %0h", st3, ST_IDLE); end
    checks++; if (state !== ST_RUN) begin errors++; $display("FAIL halt_resume_st: got %0h expected %0h", state, ST_RUN); end
    slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (np !== 1 || fe !== 3) begin
      errors++; $display("FAIL halt_resume: got count=%0d edge=%0d expected 1/3", np, fe);
    end
    checks++; if (tick_count !== 16'd3) begin errors++; $display("FAIL halt_tick: got %0h expected 3", tick_count); end
  endtask

  task automatic test_step_halt();
    int np, fe, dbl;
    logic [1:0] st3;
    run_mode = 1'b0;
    idle(2);
    press_button();
    checks++; if (state !== ST_STEP_PEND) begin errors++; $display("FAIL sh_pend: got %0h expected %0h", state, ST_STEP_PEND); end
    halt_req = 1'b1;
    idle(1);
    halt_req = 1'b0;
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL sh_state: got %0h expected %0h", state, ST_IDLE); end
    slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (np !== 0 || tick_count !== 16'd3) begin
      errors++; $display("FAIL sh_nopulse: got pulses=%0d tick=%0h expected 0/3", np, tick_count);
    end
  endtask

  task automatic test_wrap();
    int np, fe, dbl;
    logic [1:0] st3;
    run_mode = 1'b1;
    idle(2);
    force dut.tick_q = 16'hFFFF;
    idle(1);
    release dut.tick_q;
    idle(1);
    checks++; if (tick_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h expected ffff", tick_count); end
    slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (np !== 1 || tick_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got pulses=%0d tick=%0h expected 1/0", np, tick_count);
    end
    slow_period(0, 0, np, fe, dbl, st3);
    checks++; if (tick_count !== 16'd1) begin errors++; $display("FAIL wrap_one: got %0h expected 1", tick_count); end
    slow_period(0, 3, np, fe, dbl, st3);
    checks++; if (np !== 1 || tick_count !== 16'h0) begin
      errors++; $display("FAIL clr_wins: got pulses=%0d tick=%0h expected 1/0", np, tick_count);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_reset_mid_run();
    test_step();
    test_no_queue();
    test_halt();
    test_step_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_cpu_clk_stepper
`default_nettype wire
